// File: rtl/branch_resolution_queue.sv
// In-flight conditional branch queue: trains the predictor on resolve and redirects/flushes on mispredict.
// Latency 1 cycle resolve->feedback; push_ready drops when full or flushing. Optional stats: BRANCH_RESOLUTION_STATS_EN.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

package mips_core_pkg;
    typedef enum logic {NOT_TAKEN = 1'b0, TAKEN = 1'b1} BranchOutcome;
endpackage

module branch_resolution_queue
    import mips_core_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push_valid,
    input  logic [`ADDR_WIDTH-1:0] i_push_pc,
    input  BranchOutcome           i_push_prediction,
    input  logic [`ADDR_WIDTH-1:0] i_push_alt_target,
    output logic                   o_push_ready,
    input  logic                   i_resolve_valid,
    input  BranchOutcome           i_resolve_outcome,
    output logic                   o_fb_valid,
    output logic [`ADDR_WIDTH-1:0] o_fb_pc,
    output BranchOutcome           o_fb_prediction,
    output BranchOutcome           o_fb_outcome,
    output logic                   o_redirect_valid,
    output logic [`ADDR_WIDTH-1:0] o_redirect_pc,
    output logic                   o_flush,
    output logic [$clog2(DEPTH):0] o_occupancy,
    output logic                   o_error
`ifdef BRANCH_RESOLUTION_STATS_EN
    ,
    output logic [31:0]            o_stat_branches,
    output logic [31:0]            o_stat_mispredicts
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [PW-1:0]            head, tail;
    logic [OW-1:0]            occ;
    logic [`ADDR_WIDTH-1:0]   pc_mem  [DEPTH];
    logic [`ADDR_WIDTH-1:0]   alt_mem [DEPTH];
    BranchOutcome             pred_mem[DEPTH];

    logic running, push_ready, push_acc, pop, mispredict, proto_err;

    assign running    = (state_q == RUN);
    assign push_ready = running && (occ < OW'(DEPTH));
    assign push_acc   = i_push_valid && push_ready;
    // The pop decision uses pre-push occupancy, so a push into an empty queue is never resolved the same cycle.
    assign pop        = i_resolve_valid && running && (occ != '0);
    assign mispredict = pop && (i_resolve_outcome != pred_mem[head]);
    assign proto_err  = running && ((i_push_valid && !push_ready) ||
                                    (i_resolve_valid && (occ == '0)));

    assign o_push_ready = push_ready;
    assign o_flush      = (state_q == FLUSH);
    assign o_occupancy  = occ;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (mispredict) begin
                    state_d = FLUSH;
                    cnt_d   = CW'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt_q == '0) state_d = RUN;
                else             cnt_d   = cnt_q - CW'(1);
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_acc) begin
            pc_mem[tail]   <= i_push_pc;
            pred_mem[tail] <= i_push_prediction;
            alt_mem[tail]  <= i_push_alt_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= RUN;
            cnt_q            <= '0;
            head             <= '0;
            tail             <= '0;
            occ              <= '0;
            o_fb_valid       <= 1'b0;
            o_fb_pc          <= '0;
            o_fb_prediction  <= NOT_TAKEN;
            o_fb_outcome     <= NOT_TAKEN;
            o_redirect_valid <= 1'b0;
            o_redirect_pc    <= '0;
            o_error          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            o_fb_valid       <= pop;
            o_redirect_valid <= mispredict;
            if (pop) begin
                o_fb_pc         <= pc_mem[head];
                o_fb_prediction <= pred_mem[head];
                o_fb_outcome    <= i_resolve_outcome;
            end
            if (mispredict) o_redirect_pc <= alt_mem[head];
            if (proto_err)  o_error       <= 1'b1;
            // A mispredict squashes every younger entry, including a push landing this cycle.
            if (mispredict) begin
                head <= '0;
                tail <= '0;
                occ  <= '0;
            end else begin
                if (pop)      head <= head + PW'(1);
                if (push_acc) tail <= tail + PW'(1);
                case ({push_acc, pop})
                    2'b10:   occ <= occ + OW'(1);
                    2'b01:   occ <= occ - OW'(1);
                    default: occ <= occ;
                endcase
            end
        end
    end

`ifdef BRANCH_RESOLUTION_STATS_EN
    logic [31:0] stat_br, stat_mis;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_br  <= '0;
            stat_mis <= '0;
        end else begin
            if (pop)        stat_br  <= stat_br + 32'd1;
            if (mispredict) stat_mis <= stat_mis + 32'd1;
        end
    end

    assign o_stat_branches    = stat_br;
    assign o_stat_mispredicts = stat_mis;
`endif

endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue with a queue-based reference model checked every cycle.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif

module tb_branch_resolution_queue;
    import mips_core_pkg::*;

    localparam int DEPTH        = 4;
    localparam int FLUSH_CYCLES = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   i_push_valid;
    logic [`ADDR_WIDTH-1:0] i_push_pc;
    BranchOutcome           i_push_prediction;
    logic [`ADDR_WIDTH-1:0] i_push_alt_target;
    logic                   o_push_ready;
    logic                   i_resolve_valid;
    BranchOutcome           i_resolve_outcome;
    logic                   o_fb_valid;
    logic [`ADDR_WIDTH-1:0] o_fb_pc;
    BranchOutcome           o_fb_prediction;
    BranchOutcome           o_fb_outcome;
    logic                   o_redirect_valid;
    logic [`ADDR_WIDTH-1:0] o_redirect_pc;
    logic                   o_flush;
    logic [$clog2(DEPTH):0] o_occupancy;
    logic                   o_error;
`ifdef BRANCH_RESOLUTION_STATS_EN
    logic [31:0]            o_stat_branches;
    logic [31:0]            o_stat_mispredicts;
`endif

    branch_resolution_queue #(.DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_push_valid      (i_push_valid),
        .i_push_pc         (i_push_pc),
        .i_push_prediction (i_push_prediction),
        .i_push_alt_target (i_push_alt_target),
        .o_push_ready      (o_push_ready),
        .i_resolve_valid   (i_resolve_valid),
        .i_resolve_outcome (i_resolve_outcome),
        .o_fb_valid        (o_fb_valid),
        .o_fb_pc           (o_fb_pc),
        .o_fb_prediction   (o_fb_prediction),
        .o_fb_outcome      (o_fb_outcome),
        .o_redirect_valid  (o_redirect_valid),
        .o_redirect_pc     (o_redirect_pc),
        .o_flush           (o_flush),
        .o_occupancy       (o_occupancy),
        .o_error           (o_error)
`ifdef BRANCH_RESOLUTION_STATS_EN
        ,
        .o_stat_branches   (o_stat_branches),
        .o_stat_mispredicts(o_stat_mispredicts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a list of pending branches plus a flush countdown.
    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [31:0] alt;
    } ent_t;

    ent_t        mq[$];
    ent_t        m_head;
    int          m_flush_left = 0;
    bit          m_err = 0, m_fb_vld = 0, m_rd_vld = 0;
    logic [31:0] m_fb_pc = 0, m_rd_pc = 0;
    logic        m_fb_pred = 0, m_fb_out = 0;
    bit          m_full, m_mis;
    bit          started = 0;

    always @(posedge clk) begin
        started = 1;
        if (!rst_n) begin
            mq.delete();
            m_flush_left = 0;
            m_err = 0; m_fb_vld = 0; m_rd_vld = 0;
            m_fb_pc = 0; m_rd_pc = 0; m_fb_pred = 0; m_fb_out = 0;
        end else begin
            m_fb_vld = 0;
            m_rd_vld = 0;
            if (m_flush_left > 0) begin
                m_flush_left--;
            end else begin
                m_full = (mq.size() >= DEPTH);
                m_mis  = 0;
                if (i_push_valid && m_full) m_err = 1;
                if (i_resolve_valid && mq.size() == 0) m_err = 1;
                if (i_resolve_valid && mq.size() > 0) begin
                    m_head    = mq.pop_front();
                    m_fb_vld  = 1;
                    m_fb_pc   = m_head.pc;
                    m_fb_pred = m_head.pred;
                    m_fb_out  = i_resolve_outcome;
                    if (m_head.pred != i_resolve_outcome) begin
                        m_mis    = 1;
                        m_rd_vld = 1;
                        m_rd_pc  = m_head.alt;
                    end
                end
                if (i_push_valid && !m_full)
                    mq.push_back('{pc: i_push_pc, pred: i_push_prediction, alt: i_push_alt_target});
                if (m_mis) begin
                    mq.delete();
                    m_flush_left = FLUSH_CYCLES;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("push_ready", 32'(o_push_ready), 32'(m_flush_left == 0 && mq.size() < DEPTH));
            check("occupancy", 32'(o_occupancy), 32'(mq.size()));
            check("flush", 32'(o_flush), 32'(m_flush_left > 0));
            check("error", 32'(o_error), 32'(m_err));
            check("fb_valid", 32'(o_fb_valid), 32'(m_fb_vld));
            check("fb_pc", o_fb_pc, m_fb_pc);
            check("fb_prediction", 32'(o_fb_prediction), 32'(m_fb_pred));
            check("fb_outcome", 32'(o_fb_outcome), 32'(m_fb_out));
            check("redirect_valid", 32'(o_redirect_valid), 32'(m_rd_vld));
            check("redirect_pc", o_redirect_pc, m_rd_pc);
        end
    end

    task automatic step(input bit pv, input logic [31:0] pc, input bit pp, input logic [31:0] alt,
                        input bit rv, input bit ro);
        i_push_valid      = pv;
        i_push_pc         = pc;
        i_push_prediction = BranchOutcome'(pp);
        i_push_alt_target = alt;
        i_resolve_valid   = rv;
        i_resolve_outcome = BranchOutcome'(ro);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 32'h0, 0, 32'h0, 0, 0);
    endtask

    int fb_count;

    initial begin
        rst_n = 1'b0;
        i_push_valid = 0; i_push_pc = 0; i_push_prediction = NOT_TAKEN;
        i_push_alt_target = 0; i_resolve_valid = 0; i_resolve_outcome = NOT_TAKEN;
        repeat (2) @(negedge clk);
        check("lit_rst_occ", 32'(o_occupancy), 32'd0);
        check("lit_rst_ready", 32'(o_push_ready), 32'd1);
        check("lit_rst_fb_pc", o_fb_pc, 32'h0);
        check("lit_rst_rd_pc", o_redirect_pc, 32'h0);
        rst_n = 1'b1;

        // Correct prediction
        step(1, 32'h100, 1, 32'h108, 0, 0);
        check("lit_t1_occ1", 32'(o_occupancy), 32'd1);
        step(0, 32'h0, 0, 32'h0, 1, 1);
        check("lit_t1_fb_valid", 32'(o_fb_valid), 32'd1);
        check("lit_t1_fb_pc", o_fb_pc, 32'h100);
        check("lit_t1_no_redirect", 32'(o_redirect_valid), 32'd0);
        check("lit_t1_occ0", 32'(o_occupancy), 32'd0);

        // Mispredict with a same-cycle push that must be squashed
        step(1, 32'h200, 0, 32'h240, 0, 0);
        step(1, 32'h300, 1, 32'h308, 1, 1);
        check("lit_t2_rd_valid", 32'(o_redirect_valid), 32'd1);
        check("lit_t2_rd_pc", o_redirect_pc, 32'h240);
        check("lit_t2_flush1", 32'(o_flush), 32'd1);
        check("lit_t2_occ_cleared", 32'(o_occupancy), 32'd0);
        step(1, 32'h400, 1, 32'h408, 1, 1);
        check("lit_t2_flush2", 32'(o_flush), 32'd1);
        check("lit_t2_no_err", 32'(o_error), 32'd0);
        step(1, 32'h500, 1, 32'h508, 1, 0);
        check("lit_t2_flush_done", 32'(o_flush), 32'd0);
        check("lit_t2_pushes_ignored", 32'(o_occupancy), 32'd0);
        check("lit_t2_rd_pc_hold", o_redirect_pc, 32'h240);

        // Overfill
        for (int i = 0; i < 4; i++) step(1, 32'h10 * (i + 1), 1, 32'h1000 + i, 0, 0);
        check("lit_t3_occ4", 32'(o_occupancy), 32'd4);
        check("lit_t3_not_ready", 32'(o_push_ready), 32'd0);
        check("lit_t3_err0", 32'(o_error), 32'd0);
        step(1, 32'h50, 1, 32'h1004, 0, 0);
        check("lit_t3_err1", 32'(o_error), 32'd1);
        check("lit_t3_occ_still4", 32'(o_occupancy), 32'd4);

        // Streaming across pointer wrap
        fb_count = 0;
        step(0, 32'h0, 0, 32'h0, 1, 1);
        fb_count += int'(o_fb_valid);
        check("lit_t4_first_fb", o_fb_pc, 32'h10);
        check("lit_t4_occ3", 32'(o_occupancy), 32'd3);
        for (int i = 0; i < 3; i++) begin
            step(1, 32'h60 + 32'h10 * i, i[0], 32'h2000 + i, 1, 1);
            fb_count += int'(o_fb_valid);
        end
        check("lit_t4_occ_steady", 32'(o_occupancy), 32'd3);
        step(1, 32'h90, 1, 32'h2003, 1, 0);
        fb_count += int'(o_fb_valid);
        check("lit_t4_fb_60", o_fb_pc, 32'h60);
        step(0, 32'h0, 0, 32'h0, 1, 1);
        fb_count += int'(o_fb_valid);
        step(0, 32'h0, 0, 32'h0, 1, 0);
        fb_count += int'(o_fb_valid);
        step(0, 32'h0, 0, 32'h0, 1, 1);
        fb_count += int'(o_fb_valid);
        check("lit_t4_last_fb", o_fb_pc, 32'h90);
        check("lit_t4_empty", 32'(o_occupancy), 32'd0);
        check("lit_t4_fb_count", 32'(fb_count), 32'd8);
        idle();

        // Resolve on empty
        rst_n = 1'b0;
        idle();
        check("lit_t5_err_cleared", 32'(o_error), 32'd0);
        rst_n = 1'b1;
        step(0, 32'h0, 0, 32'h0, 1, 1);
        check("lit_t5_no_fb", 32'(o_fb_valid), 32'd0);
        check("lit_t5_err", 32'(o_error), 32'd1);
        repeat (3) idle();
        check("lit_t5_err_sticky", 32'(o_error), 32'd1);

        // Reset during flush with entries pending
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        step(1, 32'hA0, 1, 32'hA4, 0, 0);
        step(1, 32'hB0, 1, 32'hB4, 0, 0);
        step(1, 32'hC0, 1, 32'hC4, 0, 0);
        step(0, 32'h0, 0, 32'h0, 1, 0);
        check("lit_t6_rd_valid", 32'(o_redirect_valid), 32'd1);
        check("lit_t6_rd_pc", o_redirect_pc, 32'hA4);
        rst_n = 1'b0;
        step(1, 32'hD0, 1, 32'hD4, 1, 1);
        check("lit_t6_flush0", 32'(o_flush), 32'd0);
        check("lit_t6_occ0", 32'(o_occupancy), 32'd0);
        check("lit_t6_fb_pc0", o_fb_pc, 32'h0);
        check("lit_t6_rd_pc0", o_redirect_pc, 32'h0);
        check("lit_t6_ready", 32'(o_push_ready), 32'd1);
        rst_n = 1'b1;
        repeat (4) idle();
        check("lit_t6_no_fb", 32'(o_fb_valid), 32'd0);
        check("lit_t6_still_empty", 32'(o_occupancy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_resolution_queue.md
BRANCH_RESOLUTION_QUEUE -- requirements
Module: branch_resolution_queue

Interface
REQ-001 Parameter DEPTH, default 4, in-flight branch entries; SHALL be a power of two and at least 2.
REQ-002 Parameter FLUSH_CYCLES, default 2, number of cycles o_flush stays high after a mispredict.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_push_valid  input  1  decode pushes one predicted conditional branch.
REQ-006 i_push_pc  input  `ADDR_WIDTH  PC of pushed branch.
REQ-007 i_push_prediction  input  mips_core_pkg::BranchOutcome  predictor output for pushed branch.
REQ-008 i_push_alt_target  input  `ADDR_WIDTH  recovery address (path not chosen by prediction).
REQ-009 o_push_ready  output  1  queue accepts a push this cycle.
REQ-010 i_resolve_valid  input  1  execute resolves the oldest entry.
REQ-011 i_resolve_outcome  input  mips_core_pkg::BranchOutcome  actual outcome.
REQ-012 o_fb_valid / o_fb_pc / o_fb_prediction / o_fb_outcome  output  1/`ADDR_WIDTH/1/1  predictor training feedback.
REQ-013 o_redirect_valid / o_redirect_pc  output  1/`ADDR_WIDTH  fetch redirect on mispredict.
REQ-014 o_flush  output  1  pipeline flush in progress.
REQ-015 o_occupancy  output  $clog2(DEPTH)+1  valid entry count.
REQ-016 o_error  output  1  sticky protocol error flag.

Function
REQ-017 Storage SHALL be a circular FIFO; head/tail pointers wrap from DEPTH-1 to 0.
REQ-018 o_push_ready SHALL be 1 only when state is RUN and occupancy < DEPTH (no same-cycle pop bypass).
REQ-019 Push with i_push_valid & o_push_ready SHALL write {pc, prediction, alt_target} at tail; push without ready SHALL be dropped and set o_error.
REQ-020 Resolve in RUN with occupancy > 0 SHALL pop head; resolve with occupancy 0 SHALL be ignored and set o_error; a same-cycle push to an empty queue SHALL NOT be resolved that cycle.
REQ-021 Simultaneous accepted push and correct-prediction pop SHALL leave occupancy unchanged.
REQ-022 One cycle after a valid pop, o_fb_valid SHALL pulse one cycle with the head's pc and prediction and the resolve outcome (registered outputs).
REQ-023 Mispredict (outcome != stored prediction) SHALL, in the same cycle as o_fb_valid, pulse o_redirect_valid with o_redirect_pc = stored alt_target.
REQ-024 Mispredict SHALL clear all entries (occupancy 0 next cycle), including any same-cycle push.
REQ-025 FSM states RUN and FLUSH: RUN->FLUSH on mispredict; FLUSH holds FLUSH_CYCLES cycles, then ->RUN.
REQ-026 o_flush SHALL be 1 exactly during FLUSH; pushes and resolves in FLUSH SHALL be ignored without setting o_error.
REQ-027 o_redirect_pc and o_fb_* data SHALL hold last value when their valid is low.

Reset
REQ-028 rst_n low at a clock edge SHALL set state RUN, pointers 0, occupancy 0, o_fb_valid 0, o_redirect_valid 0, o_flush 0, o_error 0, o_fb_pc/o_redirect_pc 0, o_fb_prediction/o_fb_outcome NOT_TAKEN.
REQ-029 Reset asserted mid-FLUSH or with entries pending SHALL discard all state; no feedback or redirect SHALL emit for discarded entries.
REQ-030 Reset SHALL take priority over push and resolve in the same cycle.

Configuration
REQ-031 With BRANCH_RESOLUTION_STATS_EN defined, outputs o_stat_branches and o_stat_mispredicts (32 bits each) SHALL count valid pops and mispredicts, wrap at 2^32, reset to 0.
REQ-032 Without BRANCH_RESOLUTION_STATS_EN, those ports and counters SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Push pc 0x100 pred TAKEN alt 0x108, resolve TAKEN -> next cycle o_fb_valid=1, o_fb_pc=0x100, no redirect, occupancy 0.
REQ-034 Push pc 0x200 pred NOT_TAKEN alt 0x240, resolve TAKEN -> o_redirect_valid=1, o_redirect_pc=0x240, o_flush high 2 cycles, pushes ignored then.
REQ-035 Push 5 entries DEPTH=4 -> o_push_ready=0 after 4th, 5th dropped, o_error=1, occupancy 4.
REQ-036 Fill 4, resolve 4 correct while pushing 4 more -> FIFO order preserved across pointer wrap, 8 feedback pulses in push order.
REQ-037 Resolve on empty queue -> no o_fb_valid, o_error=1 sticky until reset.
REQ-038 Three entries pending, mispredict on head, rst_n low during FLUSH -> all outputs at reset values, no further feedback.
